// File: rtl/raycast_pkg.sv
// Shared types, tile map, wall-height and colour tables for the column raycaster.
// Pure constants; no logic, no latency.
package raycast_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT_COL,
    S_MARCH,
    S_WRITE
  } state_t;

  localparam int         NUM_COLS   = 128;
  localparam int         CELL_SHIFT = 5;
  localparam int         MAP_W      = 20;
  localparam int         MAP_H      = 15;
  localparam logic [9:0] VIEW_X0    = 10'd64;
  localparam logic [9:0] HORIZON_Y  = 10'd240;
  localparam logic [7:0] MAX_STEPS  = 8'd255;

  // Row-major map, cell cx sits at MAP[cy][cx]; border type 1, interior blocks types 2/3.
  localparam logic [19:0][1:0] MAP [15] = '{
    40'h55_5555_5555,
    40'h40_0000_0001,
    40'h40_0000_0A01,
    40'h40_0000_0A01,
    40'h40_0000_0001,
    40'h40_0200_0001,
    40'h40_0000_0001,
    40'h40_0000_0001,
    40'h40_0000_0001,
    40'h40_0000_0001,
    40'h40_0000_0001,
    40'h40_F000_0001,
    40'h40_F000_0001,
    40'h40_0000_0001,
    40'h55_5555_5555
  };

  // Wall half-height by quarter step count: min(240, floor(1024/(i+1))).
  localparam logic [7:0] HLUT [64] = '{
    8'd240, 8'd240, 8'd240, 8'd240, 8'd204, 8'd170, 8'd146, 8'd128,
    8'd113, 8'd102, 8'd93,  8'd85,  8'd78,  8'd73,  8'd68,  8'd64,
    8'd60,  8'd56,  8'd53,  8'd51,  8'd48,  8'd46,  8'd44,  8'd42,
    8'd40,  8'd39,  8'd37,  8'd36,  8'd35,  8'd34,  8'd33,  8'd32,
    8'd31,  8'd30,  8'd29,  8'd28,  8'd27,  8'd26,  8'd26,  8'd25,
    8'd24,  8'd24,  8'd23,  8'd23,  8'd22,  8'd22,  8'd21,  8'd21,
    8'd20,  8'd20,  8'd20,  8'd19,  8'd19,  8'd18,  8'd18,  8'd18,
    8'd17,  8'd17,  8'd17,  8'd17,  8'd16,  8'd16,  8'd16,  8'd16
  };

  localparam logic [11:0] PALETTE [4] = '{12'h000, 12'hAAA, 12'h0AF, 12'hFA0};

endpackage

// File: rtl/wall_map_rom.sv
// Tile-map lookup (cx,cy) -> cell type; cells off the 20x15 map read as boundary type 3.
// Combinational, zero latency; no flow control.
module wall_map_rom
  import raycast_pkg::*;
(
  input  logic [4:0] cx_i,
  input  logic [4:0] cy_i,
  output logic [1:0] type_o
);

  always_comb begin
    type_o = 2'd3;
    if (cx_i < 5'(MAP_W) && cy_i < 5'(MAP_H))
      type_o = MAP[cy_i[3:0]][cx_i];
  end

endmodule

// File: rtl/column_raycaster.sv
// Casts 128 fixed-step rays per frame into a column buffer and decodes it into wall strips.
// Cast up to 128*258 cycles after frame_start (ignored while busy); read path zero latency.
module column_raycaster
  import raycast_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic [9:0]  X,
  input  logic [9:0]  Y,
  input  logic [7:0]  x_vec,
  input  logic [7:0]  y_vec,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        wall_on,
  output logic [11:0] wall_color,
  output logic [9:0]  debugX,
  output logic [9:0]  debugY,
  output logic [11:0] debug_color,
  output logic        busy
);

  state_t             state_q, state_d;
  logic [6:0]         c_q, c_d;
  logic [7:0]         steps_q, steps_d;
  logic signed [19:0] posx_q, posx_d, posy_q, posy_d;
  logic [9:0]         xl_q, xl_d, yl_q, yl_d;
  logic [7:0]         xv_q, xv_d, yv_q, yv_d;
  logic [1:0]         hty_q, hty_d;
  logic [9:0]         dbgx_q, dbgx_d, dbgy_q, dbgy_d;
  logic [11:0]        dbgc_q, dbgc_d;
  logic               wr_en;

  logic [7:0]         hh_q [NUM_COLS];
  logic [1:0]         ty_q [NUM_COLS];

  logic signed [15:0] xv_e, yv_e, coff, ray_dx, ray_dy;
  logic signed [19:0] stepx, stepy;
  logic [1:0]         rom_type, hit_type;
  logic               oob;

  assign xv_e   = {{8{xv_q[7]}}, xv_q};
  assign yv_e   = {{8{yv_q[7]}}, yv_q};
  assign coff   = {9'd0, c_q} - 16'd64;
  assign ray_dx = xv_e * 16'sd64 - yv_e * coff;
  assign ray_dy = yv_e * 16'sd64 + xv_e * coff;
  // Arithmetic >>>4 of the 16-bit ray, sign-extended into the 12.8 position format.
  assign stepx  = {{8{ray_dx[15]}}, ray_dx[15:4]};
  assign stepy  = {{8{ray_dy[15]}}, ray_dy[15:4]};

  wall_map_rom u_rom (
    .cx_i  (posx_q[8+CELL_SHIFT +: 5]),
    .cy_i  (posy_q[8+CELL_SHIFT +: 5]),
    .type_o(rom_type)
  );

  assign oob = posx_q[19] | (posx_q[18:8] > 11'd639) |
               posy_q[19] | (posy_q[18:8] > 11'd479);
  assign hit_type = oob ? 2'd3 : rom_type;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    steps_d = steps_q;
    posx_d  = posx_q;
    posy_d  = posy_q;
    xl_d    = xl_q;
    yl_d    = yl_q;
    xv_d    = xv_q;
    yv_d    = yv_q;
    hty_d   = hty_q;
    dbgx_d  = dbgx_q;
    dbgy_d  = dbgy_q;
    dbgc_d  = dbgc_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          xl_d    = X;
          yl_d    = Y;
          xv_d    = x_vec;
          yv_d    = y_vec;
          c_d     = 7'd0;
          state_d = S_INIT_COL;
        end
      end
      S_INIT_COL: begin
        posx_d  = {2'b00, xl_q, 8'h00};
        posy_d  = {2'b00, yl_q, 8'h00};
        steps_d = 8'd0;
        state_d = S_MARCH;
      end
      S_MARCH: begin
        if (hit_type != 2'd0 || steps_q == MAX_STEPS) begin
          hty_d   = hit_type;
          state_d = S_WRITE;
        end else begin
          posx_d  = posx_q + stepx;
          posy_d  = posy_q + stepy;
          steps_d = steps_q + 8'd1;
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (c_q == 7'd64) begin
          dbgx_d = posx_q[17:8];
          dbgy_d = posy_q[17:8];
          dbgc_d = (hty_q != 2'd0) ? 12'hF00 : 12'h0F0;
        end
        if (c_q == 7'(NUM_COLS - 1)) begin
          state_d = S_IDLE;
        end else begin
          c_d     = c_q + 7'd1;
          state_d = S_INIT_COL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      steps_q <= '0;
      posx_q  <= '0;
      posy_q  <= '0;
      xl_q    <= '0;
      yl_q    <= '0;
      xv_q    <= '0;
      yv_q    <= '0;
      hty_q   <= '0;
      dbgx_q  <= '0;
      dbgy_q  <= '0;
      dbgc_q  <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      steps_q <= steps_d;
      posx_q  <= posx_d;
      posy_q  <= posy_d;
      xl_q    <= xl_d;
      yl_q    <= yl_d;
      xv_q    <= xv_d;
      yv_q    <= yv_d;
      hty_q   <= hty_d;
      dbgx_q  <= dbgx_d;
      dbgy_q  <= dbgy_d;
      dbgc_q  <= dbgc_d;
    end
  end

  // A ray that runs out of steps leaves hty_q=0 and steps=255, i.e. type 0 with HLUT[63].
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        hh_q[i] <= '0;
        ty_q[i] <= '0;
      end
    end else if (wr_en) begin
      hh_q[c_q] <= HLUT[steps_q[7:2]];
      ty_q[c_q] <= hty_q;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign debugX      = dbgx_q;
  assign debugY      = dbgy_q;
  assign debug_color = dbgc_q;

  logic        in_view;
  logic [6:0]  rcol;
  logic [9:0]  dy;
  logic [7:0]  rhh;
  logic [11:0] base;

  assign in_view = (DrawX >= VIEW_X0) && (DrawX < VIEW_X0 + 10'd512);
  assign rcol    = 7'((DrawX - VIEW_X0) >> 2);
  assign dy      = (DrawY >= HORIZON_Y) ? (DrawY - HORIZON_Y) : (HORIZON_Y - DrawY);
  assign rhh     = hh_q[rcol];
  assign base    = PALETTE[ty_q[rcol]];

  assign wall_on    = in_view && ({2'b00, rhh} > dy);
  // Distant (short) walls are dimmed to half intensity per channel.
  assign wall_color = (rhh < 8'd32) ? ((base >> 1) & 12'h777) : base;

endmodule

// File: tb/tb_column_raycaster.sv
// Directed bench for column_raycaster: reset, straight wall, reset mid-cast,
// zero vector with busy guard and mid-cast input changes, viewport edges.
module tb_column_raycaster;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic [9:0]  X, Y, DrawX, DrawY;
  logic [7:0]  x_vec, y_vec;
  logic        wall_on, busy;
  logic [11:0] wall_color, debug_color;
  logic [9:0]  debugX, debugY;

  int total = 0;
  int bad   = 0;
  int n;

  column_raycaster dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .X          (X),
    .Y          (Y),
    .x_vec      (x_vec),
    .y_vec      (y_vec),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .wall_on    (wall_on),
    .wall_color (wall_color),
    .debugX     (debugX),
    .debugY     (debugY),
    .debug_color(debug_color),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setpix(input logic [9:0] x, input logic [9:0] y);
    DrawX = x;
    DrawY = y;
    #1;
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0;
    X = 10'd0; Y = 10'd0; x_vec = 8'd0; y_vec = 8'd0;
    DrawX = 10'd100; DrawY = 10'd300;

    // Reset
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    setpix(10'd100, 10'd240);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wall_on", wall_on, 1'b0);
    chk("rst_debugX", debugX, 10'd0);
    chk("rst_debugY", debugY, 10'd0);
    chk("rst_debug_color", debug_color, 12'h000);

    // Straight wall ahead: centre ray 146 steps -> half height 27
    X = 10'd320; Y = 10'd240; x_vec = 8'd127; y_vec = 8'd0;
    @(negedge Clk) frame_start = 1'b1;
    @(negedge Clk) frame_start = 1'b0;
    chk("wall_busy_rise", busy, 1'b1);
    n = 0;
    while (busy && n < 40000) begin n++; @(negedge Clk); end
    chk("wall_cast_bounded", 32'(n <= 33024), 32'd1);
    chk("wall_debugX", debugX, 10'd609);
    chk("wall_debugY", debugY, 10'd240);
    chk("wall_debug_color", debug_color, 12'hF00);
    for (int x = 320; x <= 323; x++) begin
      setpix(10'(x), 10'd214); chk("wall_top_in", wall_on, 1'b1);
      setpix(10'(x), 10'd266); chk("wall_bot_in", wall_on, 1'b1);
    end
    setpix(10'd320, 10'd213); chk("wall_top_out", wall_on, 1'b0);
    setpix(10'd320, 10'd267); chk("wall_bot_out", wall_on, 1'b0);
    setpix(10'd321, 10'd240); chk("wall_color_dim", wall_color, 12'h555);

    // Reset mid-cast clears the buffer
    x_vec = 8'd0; y_vec = 8'd0;
    @(negedge Clk) frame_start = 1'b1;
    @(negedge Clk) frame_start = 1'b0;
    repeat (4998) @(negedge Clk);
    chk("midrst_busy_before", busy, 1'b1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midrst_busy_after", busy, 1'b0);
    Reset = 1'b0;
    for (int c = 0; c < 128; c++) begin
      setpix(10'(64 + 4 * c), 10'd240);
      chk("midrst_cleared", wall_on, 1'b0);
    end
    chk("midrst_debug_color", debug_color, 12'h000);

    // Zero vector: every column steps out; busy guard and inputs change mid-cast
    X = 10'd320; Y = 10'd240; x_vec = 8'd0; y_vec = 8'd0;
    @(negedge Clk) frame_start = 1'b1;
    @(negedge Clk) frame_start = 1'b0;
    n = 0;
    while (busy && n < 40000) begin
      n++;
      frame_start = (n == 1000);
      if (n == 1000) begin
        X = 10'd100; Y = 10'd100; x_vec = 8'd127; y_vec = 8'd50;
      end
      @(negedge Clk);
    end
    frame_start = 1'b0;
    chk("zero_cast_cycles", n, 32'd33024);
    chk("zero_debug_color", debug_color, 12'h0F0);
    chk("zero_debugX", debugX, 10'd320);
    chk("zero_debugY", debugY, 10'd240);
    setpix(10'd64, 10'd225);  chk("zero_c0_in", wall_on, 1'b1);
    setpix(10'd64, 10'd224);  chk("zero_c0_out", wall_on, 1'b0);
    setpix(10'd320, 10'd255); chk("zero_c64_in", wall_on, 1'b1);
    setpix(10'd320, 10'd256); chk("zero_c64_out", wall_on, 1'b0);
    setpix(10'd572, 10'd240); chk("zero_c127_in", wall_on, 1'b1);
    setpix(10'd320, 10'd240); chk("zero_color", wall_color, 12'h000);

    // Viewport edges
    setpix(10'd575, 10'd240); chk("edge_575", wall_on, 1'b1);
    setpix(10'd63, 10'd240);  chk("edge_63", wall_on, 1'b0);
    setpix(10'd576, 10'd240); chk("edge_576", wall_on, 1'b0);
    chk("final_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
